rwd_arbiter: RTL

RWD_ARBITER -- requirements
Module: rwd_arbiter

---
 rtl/rwd_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rwd_arbiter.sv
// Round-robin arbiter that feeds N_REQ requesters into one fixed-latency reward pipeline
// and routes each returned reward back to its owner using a tag line that tracks the pipeline.
module rwd_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TH_WL     = 32,
    parameter int TH_DOT_WL = 32,
    parameter int TOR_WL    = 32,
    parameter int RWD_WL    = 32,
    parameter int PIPE_LAT  = 16,
    parameter int ID_WL     = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*TH_WL-1:0]     i_req_th,
    input  logic [N_REQ*TH_DOT_WL-1:0] i_req_thdot,
    input  logic [N_REQ*TOR_WL-1:0]    i_req_tor,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_pipe_ena,
    output logic [TH_WL-1:0]           o_pipe_th,
    output logic [TH_DOT_WL-1:0]       o_pipe_thdot,
    output logic [TOR_WL-1:0]          o_pipe_tor,
    input  logic                       i_pipe_rwd_valid,
    input  logic [RWD_WL-1:0]          i_pipe_rwd,
    output logic                       o_rsp_valid,
    output logic [ID_WL-1:0]           o_rsp_id,
    output logic [RWD_WL-1:0]          o_rsp_rwd,
    output logic [ID_WL+5:0]           o_inflight,
    output logic                       o_err
);

    localparam int TAG_LEN = PIPE_LAT + 1;
    localparam int CW      = ID_WL + 1;
    localparam int CNT_WL  = ID_WL + 6;

    logic [TH_WL-1:0]     th_arr    [N_REQ];
    logic [TH_DOT_WL-1:0] thdot_arr [N_REQ];
    logic [TOR_WL-1:0]    tor_arr   [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign th_arr[gi]    = i_req_th[gi*TH_WL +: TH_WL];
            assign thdot_arr[gi] = i_req_thdot[gi*TH_DOT_WL +: TH_DOT_WL];
            assign tor_arr[gi]   = i_req_tor[gi*TOR_WL +: TOR_WL];
        end
    endgenerate

    logic [ID_WL-1:0] rr_reg;
    logic [ID_WL-1:0] grant_id;
    logic             grant_found;
    logic [CW-1:0]    cand;
    logic             issue;

    // Walk offsets from the far end so the candidate closest to rr is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_reg} + CW'(off);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (i_req_valid[cand[ID_WL-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_WL-1:0];
            end
        end
    end

    assign issue = grant_found & i_en & ~i_rst;

    always_comb begin
        o_req_ready = '0;
        if (issue) begin
            o_req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_reg <= '0;
        end else if (issue) begin
            rr_reg <= (grant_id == ID_WL'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    logic                 pipe_ena_reg;
    logic [TH_WL-1:0]     pipe_th_reg;
    logic [TH_DOT_WL-1:0] pipe_thdot_reg;
    logic [TOR_WL-1:0]    pipe_tor_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_ena_reg   <= 1'b0;
            pipe_th_reg    <= '0;
            pipe_thdot_reg <= '0;
            pipe_tor_reg   <= '0;
        end else begin
            pipe_ena_reg <= issue;
            if (issue) begin
                pipe_th_reg    <= th_arr[grant_id];
                pipe_thdot_reg <= thdot_arr[grant_id];
                pipe_tor_reg   <= tor_arr[grant_id];
            end
        end
    end

    assign o_pipe_ena   = pipe_ena_reg;
    assign o_pipe_th    = pipe_th_reg;
    assign o_pipe_thdot = pipe_thdot_reg;
    assign o_pipe_tor   = pipe_tor_reg;

    // The tail stage lines up with the cycle the pipeline is expected to present its result.
    logic [TAG_LEN-1:0] tag_valid_reg;
    logic [ID_WL-1:0]   tag_id_reg [TAG_LEN];
    logic               tail_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_valid_reg <= '0;
            for (int s = 0; s < TAG_LEN; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_valid_reg <= {tag_valid_reg[TAG_LEN-2:0], issue};
            tag_id_reg[0] <= grant_id;
            for (int s = 1; s < TAG_LEN; s++) begin
                tag_id_reg[s] <= tag_id_reg[s-1];
            end
        end
    end

    assign tail_valid = tag_valid_reg[TAG_LEN-1];

    logic              rsp_valid_reg;
    logic [ID_WL-1:0]  rsp_id_reg;
    logic [RWD_WL-1:0] rsp_rwd_reg;
    logic [CNT_WL-1:0] inflight_reg;
    logic              err_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_rwd_reg   <= '0;
            inflight_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            rsp_valid_reg <= tail_valid & i_pipe_rwd_valid;
            if (tail_valid && i_pipe_rwd_valid) begin
                rsp_id_reg  <= tag_id_reg[TAG_LEN-1];
                rsp_rwd_reg <= i_pipe_rwd;
            end
            // A lone tag or a lone result means the pipeline and tag line lost alignment.
            if (tail_valid ^ i_pipe_rwd_valid) begin
                err_reg <= 1'b1;
            end
            case ({issue, tail_valid})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_id    = rsp_id_reg;
    assign o_rsp_rwd   = rsp_rwd_reg;
    assign o_inflight  = inflight_reg;
    assign o_err       = err_reg;

endmodule
